// File: rtl/jtdsp16_loader.sv
// jtdsp16_loader: boot sequencer that streams the program ROM into jtdsp16, then releases its reset
`timescale 1ns/1ps
module jtdsp16_loader #(
  parameter int ROM_BYTES = 8192,
  parameter int RST_HOLD  = 4
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        clk_en,
  input  logic        start,
  input  logic        halt,
  output logic [12:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ok,
  input  logic [7:0]  mem_data,
  output logic [12:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        prog_we,
  output logic        dsp_rst,
  output logic        dsp_cen,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, REQ, WRITE, HOLD, RUN} state_t;
  localparam logic [12:0] LAST  = 13'(ROM_BYTES - 1);
  localparam logic [3:0]  HLAST = 4'(RST_HOLD - 1);
  state_t state, state_n;
  logic [12:0] cnt, cnt_n, addr_n, paddr_n;
  logic [7:0] pdata_n;
  logic [3:0] hcnt, hcnt_n;
  logic req_n, we_q;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hcnt_n  = hcnt;
    addr_n  = mem_addr;
    req_n   = mem_req;
    paddr_n = prog_addr;
    pdata_n = prog_data;
    case (state)
      IDLE, RUN: if (start) begin
        state_n = REQ;
        cnt_n   = '0;
        addr_n  = '0;
        req_n   = 1'b1;
      end
      REQ: if (mem_ok) begin
        state_n = WRITE;
        pdata_n = mem_data;
        paddr_n = cnt;
        req_n   = 1'b0;
      end
      WRITE: if (cnt == LAST) begin
        state_n = HOLD;
        hcnt_n  = '0;
      end else begin
        state_n = REQ;
        cnt_n   = cnt + 13'd1;
        addr_n  = cnt + 13'd1;
        req_n   = 1'b1;
      end
      HOLD: if (clk_en) begin
        state_n = hcnt == HLAST ? RUN : HOLD;
        hcnt_n  = hcnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      we_q      <= 1'b0;
      dsp_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hcnt      <= hcnt_n;
      mem_addr  <= addr_n;
      mem_req   <= req_n;
      prog_addr <= paddr_n;
      prog_data <= pdata_n;
      we_q      <= state_n == WRITE;
      dsp_rst   <= state_n != RUN;
      busy      <= state_n == REQ || state_n == WRITE || state_n == HOLD;
      done      <= state_n == RUN;
    end
  end
  assign prog_we = we_q & ~rst;
  assign dsp_cen = clk_en & (state == RUN) & ~halt;
endmodule

// File: tb/tb_jtdsp16_loader.sv
// tb_jtdsp16_loader: scoreboard bench for a 16-byte and a full 8192-byte loader
`timescale 1ns/1ps
module tb_jtdsp16_loader;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic clk_en_a = 1, start_a = 0, halt_a = 0, resp_a = 0, late_a = 0, hold_a = 0, mok_a;
  logic [7:0] mdata_a = 0, pdata_a;
  logic [12:0] maddr_a, paddr_a;
  logic mreq_a, pwe_a, drst_a, dcen_a, busy_a, done_a;
  assign mok_a = resp_a | late_a;
  jtdsp16_loader #(.ROM_BYTES(16), .RST_HOLD(4)) u_a (
    .rst(rst), .clk(clk), .clk_en(clk_en_a), .start(start_a), .halt(halt_a),
    .mem_addr(maddr_a), .mem_req(mreq_a), .mem_ok(mok_a), .mem_data(mdata_a),
    .prog_addr(paddr_a), .prog_data(pdata_a), .prog_we(pwe_a),
    .dsp_rst(drst_a), .dsp_cen(dcen_a), .busy(busy_a), .done(done_a));

  logic start_b = 0, resp_b = 0;
  logic [7:0] mdata_b = 0, pdata_b;
  logic [12:0] maddr_b, paddr_b;
  logic mreq_b, pwe_b, drst_b, dcen_b, busy_b, done_b;
  jtdsp16_loader #(.ROM_BYTES(8192), .RST_HOLD(4)) u_b (
    .rst(rst), .clk(clk), .clk_en(1'b1), .start(start_b), .halt(1'b0),
    .mem_addr(maddr_b), .mem_req(mreq_b), .mem_ok(resp_b), .mem_data(mdata_b),
    .prog_addr(paddr_b), .prog_data(pdata_b), .prog_we(pwe_b),
    .dsp_rst(drst_b), .dsp_cen(dcen_b), .busy(busy_b), .done(done_b));

  logic [20:0] qa[$], qb[$];
  logic [20:0] ea, eb;
  int since_a = 0, writes_b = 0;
  logic prev_rst_a = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a();
    for (int i = 0; i < 16; i++) qa.push_back({13'(i), 8'(i) ^ 8'h5A});
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
  endtask

  task automatic wait_done_a(input string name);
    for (int i = 0; i < 400 && !done_a; i++) @(negedge clk);
    chk(name, done_a, 1);
  endtask

  // memory model: answers one cycle after the request rises, data = addr ^ 0x5A
  int wa = 0;
  always @(negedge clk) begin
    if (mreq_a && !hold_a && !resp_a) begin
      if (wa >= 1) begin
        resp_a = 1;
        mdata_a = maddr_a[7:0] ^ 8'h5A;
        wa = 0;
      end else wa++;
    end else begin
      resp_a = 0;
      wa = 0;
    end
  end

  int wb = 0, db = 3;
  always @(negedge clk) begin
    if (mreq_b && !resp_b) begin
      if (wb >= db) begin
        resp_b = 1;
        mdata_b = maddr_b[7:0] ^ 8'h5A;
        wb = 0;
        db = $urandom_range(0, 7);
      end else wb++;
    end else begin
      resp_b = 0;
      wb = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) chk("a_we_in_rst", pwe_a, 0);
    if (pwe_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra_we: write to %0h with no write expected", paddr_a);
      end else begin
        ea = qa.pop_front();
        chk("a_prog_addr", paddr_a, ea[20:8]);
        chk("a_prog_data", pdata_a, ea[7:0]);
      end
      since_a = 0;
    end else if (!drst_a && prev_rst_a) chk("a_hold_cycles", since_a, 4);
    else if (drst_a && clk_en_a) since_a++;
    prev_rst_a = drst_a;
  end

  always @(negedge clk) begin
    if (pwe_b) begin
      writes_b++;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra_we: write to %0h with no write expected", paddr_b);
      end else begin
        eb = qb.pop_front();
        chk("b_prog_addr", paddr_b, eb[20:8]);
        chk("b_prog_data", pdata_b, eb[7:0]);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", maddr_a, 0);
    chk("rst_mem_req", mreq_a, 0);
    chk("rst_prog_addr", paddr_a, 0);
    chk("rst_prog_data", pdata_a, 0);
    chk("rst_prog_we", pwe_a, 0);
    chk("rst_dsp_rst", drst_a, 1);
    chk("rst_dsp_cen", dcen_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    @(posedge clk); #1 rst = 0;

    push_a();
    pulse_a();
    @(negedge clk);
    chk("load_busy", busy_a, 1);
    chk("load_mem_req", mreq_a, 1);
    wait_done_a("load_done");
    chk("load_dsp_rst", drst_a, 0);
    chk("load_all_written", qa.size(), 0);

    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      clk_en_a = (i % 2) == 1;
      halt_a = i >= 10 && i < 20;
      @(negedge clk);
      chk("halt_dsp_cen", dcen_a, ((i % 2) == 1 && !(i >= 10 && i < 20)) ? 1 : 0);
    end
    @(posedge clk); #1 clk_en_a = 1; halt_a = 0;

    push_a();
    pulse_a();
    @(negedge clk);
    chk("restart_dsp_rst", drst_a, 1);
    chk("restart_done", done_a, 0);
    chk("restart_mem_addr", maddr_a, 0);
    chk("restart_mem_req", mreq_a, 1);
    for (int i = 0; i < 400 && !(mreq_a && maddr_a == 13'd5); i++) @(negedge clk);
    chk("byte5_req_seen", mreq_a, 1);
    pulse_a();
    for (int i = 0; i < 400 && !(pwe_a && paddr_a == 13'd15); i++) @(negedge clk);
    chk("last_we_seen", pwe_a, 1);
    clk_en_a = 0;
    repeat (20) @(negedge clk);
    chk("hold_dsp_rst", drst_a, 1);
    chk("hold_done", done_a, 0);
    chk("hold_busy", busy_a, 1);
    @(posedge clk); #1 clk_en_a = 1;
    wait_done_a("hold_release_done");
    chk("reload_all_written", qa.size(), 0);

    push_a();
    pulse_a();
    for (int i = 0; i < 400 && !(mreq_a && maddr_a == 13'd3); i++) @(negedge clk);
    chk("byte3_req_seen", mreq_a, 1);
    hold_a = 1;
    @(posedge clk); #1 rst = 1;
    qa.delete();
    @(posedge clk); #1 rst = 0; late_a = 1;
    @(posedge clk); #1 late_a = 0;
    repeat (5) @(negedge clk);
    chk("abort_busy", busy_a, 0);
    chk("abort_dsp_rst", drst_a, 1);
    chk("abort_mem_req", mreq_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_prog_addr", paddr_a, 0);
    hold_a = 0;

    push_a();
    halt_a = 1;
    pulse_a();
    wait_done_a("halt_idle_done");
    chk("halt_idle_all_written", qa.size(), 0);
    halt_a = 0;

    for (int i = 0; i < 8192; i++) qb.push_back({13'(i), 8'(i) ^ 8'h5A});
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int i = 0; i < 90000 && !done_b; i++) @(negedge clk);
    chk("full_done", done_b, 1);
    repeat (20) @(negedge clk);
    chk("full_writes", writes_b, 8192);
    chk("full_all_written", qb.size(), 0);
    chk("full_last_addr", paddr_b, 13'h1FFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
